// File: rtl/affine_mcm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : affine_mcm_pkg
// Brief   : Shared types, coefficient table and clamp helper for the
//           affine multiple-constant-multiplier pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package affine_mcm_pkg;

  // Quarter-precision fractional position of a sample
  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_t;

  // Coefficients indexed [phase][product]; products are (y1, y2, y3).
  // The datapath realises these as shift-add/sub terms of x, 2x, 4x, 8x.
  localparam int C_TAB [4][3] = '{
    '{ 1, 3, 3},
    '{ 2, 5, 1},
    '{ 3, 7, 0},
    '{-1, 6, 4}
  };

  // Widest intermediate the clamp helper can take
  localparam int SAT_MAX_W = 64;

  // Clamp a sign-extended value into the signed range of a w-bit word
  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input logic signed [SAT_MAX_W-1:0] v,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/affine_mcm_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module  : affine_sat
// Brief   : Combinational signed clamp from ACC_W bits down to OUT_W bits,
//           flagging when the value had to be limited.
// Revision: 1.0 - initial release
// ============================================================================
module affine_sat
  import affine_mcm_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int OUT_W = 18
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamped
);

  logic signed [SAT_MAX_W-1:0] wide;
  logic signed [SAT_MAX_W-1:0] lim;

  // Sign-extend, clamp, and report whether the clamp changed the value
  always_comb begin
    wide    = SAT_MAX_W'(din);
    lim     = sat_clamp(wide, OUT_W);
    dout    = lim[OUT_W-1:0];
    clamped = (lim != wide);
  end

endmodule
`default_nettype wire

// File: rtl/affine_mcm_pipe.sv
`default_nettype none
// ============================================================================
// Module  : affine_mcm_pipe
// Brief   : Two-stage valid/ready pipeline computing three constant products
//           of a signed sample, with phase-selected coefficients, shift-add
//           arithmetic, output saturation and a sticky saturation flag.
// Revision: 1.0 - initial release
// ============================================================================
module affine_mcm_pipe
  import affine_mcm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  x,
  input  logic [1:0]              phase,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3,
  output logic                    sat,
  output logic                    sat_sticky,
  input  logic                    clear
);

  // Four guard bits cover the largest coefficient magnitude (7) plus sign
  localparam int ACC_W = IN_W + 4;

  // Stage 1: sample, phase and its shifted multiples
  logic                    s1_valid_q, s1_valid_d;
  phase_t                  phase_q, phase_d;
  logic signed [ACC_W-1:0] x1_q, x1_d;
  logic signed [ACC_W-1:0] x2_q, x2_d;
  logic signed [ACC_W-1:0] x4_q, x4_d;
  logic signed [ACC_W-1:0] x8_q, x8_d;

  // Stage 2: clamped products
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] y1_q, y1_d;
  logic signed [OUT_W-1:0] y2_q, y2_d;
  logic signed [OUT_W-1:0] y3_q, y3_d;
  logic                    sat_q, sat_d;
  logic                    sat_sticky_q, sat_sticky_d;

  logic                    s2_adv;
  logic                    s1_adv;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] p1, p2, p3;
  logic signed [OUT_W-1:0] c1_out, c2_out, c3_out;
  logic                    c1_sat, c2_sat, c3_sat;

  // A stage may load when it is empty or its content moves on this cycle
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign x_ext    = ACC_W'(x);

  // Shift-add/sub products selected by the registered phase
  always_comb begin
    p1 = x1_q;
    p2 = x2_q + x1_q;
    p3 = x2_q + x1_q;
    case (phase_q)
      PH_0: begin p1 = x1_q;         p2 = x2_q + x1_q; p3 = x2_q + x1_q; end
      PH_1: begin p1 = x2_q;         p2 = x4_q + x1_q; p3 = x1_q;        end
      PH_2: begin p1 = x2_q + x1_q;  p2 = x8_q - x1_q; p3 = '0;          end
      PH_3: begin p1 = -x1_q;        p2 = x4_q + x2_q; p3 = x4_q;        end
      default: ;
    endcase
  end

  affine_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_y1 (
    .din(p1), .dout(c1_out), .clamped(c1_sat)
  );
  affine_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_y2 (
    .din(p2), .dout(c2_out), .clamped(c2_sat)
  );
  affine_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_y3 (
    .din(p3), .dout(c3_out), .clamped(c3_sat)
  );

  // Next-state for both stages and the sticky flag
  always_comb begin
    s1_valid_d   = s1_valid_q;
    phase_d      = phase_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    x4_d         = x4_q;
    x8_d         = x8_q;
    out_valid_d  = out_valid_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    y3_d         = y3_q;
    sat_d        = sat_q;
    sat_sticky_d = sat_sticky_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        phase_d = phase_t'(phase);
        x1_d    = x_ext;
        x2_d    = x_ext <<< 1;
        x4_d    = x_ext <<< 2;
        x8_d    = x_ext <<< 3;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y1_d  = c1_out;
        y2_d  = c2_out;
        y3_d  = c3_out;
        sat_d = c1_sat || c2_sat || c3_sat;
      end else begin
        sat_d = 1'b0;
      end
    end

    // Setting wins over a simultaneous clear
    if (out_valid_q && out_ready && sat_q) begin
      sat_sticky_d = 1'b1;
    end else if (clear) begin
      sat_sticky_d = 1'b0;
    end
  end

  // State registers with synchronous reset that drops any in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      phase_q      <= PH_0;
      x1_q         <= '0;
      x2_q         <= '0;
      x4_q         <= '0;
      x8_q         <= '0;
      out_valid_q  <= 1'b0;
      y1_q         <= '0;
      y2_q         <= '0;
      y3_q         <= '0;
      sat_q        <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      phase_q      <= phase_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x4_q         <= x4_d;
      x8_q         <= x8_d;
      out_valid_q  <= out_valid_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      y3_q         <= y3_d;
      sat_q        <= sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign y1         = y1_q;
  assign y2         = y2_q;
  assign y3         = y3_q;
  assign sat        = sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_affine_mcm_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_affine_mcm_pipe
// Brief   : Scoreboard bench driving two pipeline instances (OUT_W 18 and 20)
//           from shared stimulus, checked against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_affine_mcm_pipe;

  localparam int IN_W = 16;

  typedef struct {
    longint y [3];
    bit     s;
    longint acc;
    bit     lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic clear = 1'b0;
  logic signed [IN_W-1:0] x = '0;
  logic [1:0] phase = 2'd0;
  bit lat_flag = 1'b0;

  logic ir_a, ov_a, sat_a, stk_a;
  logic ir_b, ov_b, sat_b, stk_b;
  logic signed [17:0] y1_a, y2_a, y3_a;
  logic signed [19:0] y1_b, y2_b, y3_b;

  affine_mcm_pipe #(.IN_W(IN_W), .OUT_W(18)) u_dut18 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .x(x),
    .phase(phase), .out_valid(ov_a), .out_ready(out_ready),
    .y1(y1_a), .y2(y2_a), .y3(y3_a), .sat(sat_a), .sat_sticky(stk_a),
    .clear(clear)
  );

  affine_mcm_pipe #(.IN_W(IN_W), .OUT_W(20)) u_dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .x(x),
    .phase(phase), .out_valid(ov_b), .out_ready(out_ready),
    .y1(y1_b), .y2(y2_b), .y3(y3_b), .sat(sat_b), .sat_sticky(stk_b),
    .clear(clear)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  int     coef [4][3] = '{'{1, 3, 3}, '{2, 5, 1}, '{3, 7, 0}, '{-1, 6, 4}};
  int     wid [2] = '{18, 20};
  exp_t   q0 [$];
  exp_t   q1 [$];

  longint ov [2], sv [2], stk [2], ir [2];
  longint yv [2][3];
  bit     hold [2];
  longint held [2][4];
  bit     ref_stk [2];
  bit     armed = 1'b0;
  bit     prev_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    ov[0] = longint'(ov_a);   ov[1] = longint'(ov_b);
    sv[0] = longint'(sat_a);  sv[1] = longint'(sat_b);
    stk[0] = longint'(stk_a); stk[1] = longint'(stk_b);
    ir[0] = longint'(ir_a);   ir[1] = longint'(ir_b);
    yv[0][0] = longint'(y1_a); yv[0][1] = longint'(y2_a); yv[0][2] = longint'(y3_a);
    yv[1][0] = longint'(y1_b); yv[1][1] = longint'(y2_b); yv[1][2] = longint'(y3_b);
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Exact product, then clamp into the signed range of w bits
  function automatic exp_t model(input longint xv, input int ph, input int w,
                                 input longint ac, input bit lat);
    exp_t   e;
    longint p, hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    e.s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p = xv * coef[ph][k];
      if (p > hi) begin p = hi; e.s = 1'b1; end
      else if (p < lo) begin p = lo; e.s = 1'b1; end
      e.y[k] = p;
    end
    e.acc = ac;
    e.lat = lat;
    return e;
  endfunction

  // Monitor: stability, reset state, sticky model, pop/compare, push on accept
  always @(negedge clk) begin
    exp_t e;
    bit   got;
    bit   set;
    if (armed) begin
      for (int d = 0; d < 2; d++) chk($sformatf("sat_sticky[%0d]", d), stk[d], longint'(ref_stk[d]));
    end
    if (prev_rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_out_valid[%0d]", d), ov[d], 0);
        chk($sformatf("rst_y1[%0d]", d), yv[d][0], 0);
        chk($sformatf("rst_y2[%0d]", d), yv[d][1], 0);
        chk($sformatf("rst_y3[%0d]", d), yv[d][2], 0);
        chk($sformatf("rst_sat[%0d]", d), sv[d], 0);
        chk($sformatf("rst_in_ready[%0d]", d), ir[d], 1);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (hold[d]) begin
        chk($sformatf("hold_valid[%0d]", d), ov[d], 1);
        chk($sformatf("hold_y1[%0d]", d), yv[d][0], held[d][0]);
        chk($sformatf("hold_y2[%0d]", d), yv[d][1], held[d][1]);
        chk($sformatf("hold_y3[%0d]", d), yv[d][2], held[d][2]);
        chk($sformatf("hold_sat[%0d]", d), sv[d], held[d][3]);
      end
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      ref_stk = '{1'b0, 1'b0};
      hold = '{1'b0, 1'b0};
      armed = 1'b1;
    end else if (armed) begin
      for (int d = 0; d < 2; d++) begin
        set = 1'b0;
        hold[d] = 1'b0;
        if (ov[d] != 0) begin
          if (out_ready) begin
            got = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            chk($sformatf("beat_expected[%0d]", d), longint'(got), 1);
            if (got) begin
              chk($sformatf("y1[%0d]", d), yv[d][0], e.y[0]);
              chk($sformatf("y2[%0d]", d), yv[d][1], e.y[1]);
              chk($sformatf("y3[%0d]", d), yv[d][2], e.y[2]);
              chk($sformatf("sat[%0d]", d), sv[d], longint'(e.s));
              if (e.lat) chk($sformatf("latency[%0d]", d), cyc - e.acc, 2);
              set = e.s;
            end
          end else begin
            hold[d] = 1'b1;
            held[d][0] = yv[d][0];
            held[d][1] = yv[d][1];
            held[d][2] = yv[d][2];
            held[d][3] = sv[d];
          end
        end
        ref_stk[d] = set ? 1'b1 : (clear ? 1'b0 : ref_stk[d]);
      end
      if (in_valid && ir[0] != 0) begin
        q0.push_back(model(longint'(x), int'(phase), wid[0], cyc, lat_flag));
        q1.push_back(model(longint'(x), int'(phase), wid[1], cyc, lat_flag));
      end
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_beat(input int xv, input int ph, input bit lat);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    x = IN_W'(xv);
    phase = 2'(ph);
    lat_flag = lat;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ir_a;
      step();
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    lat_flag = 1'b0;
  endtask

  initial begin
    int  sent;
    bit  saw_stall;
    int  k;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Directed values, no back-pressure
    send_beat(100, 0, 1'b1);
    idle(4);
    send_beat(-5, 3, 1'b0);
    send_beat(-1, 1, 1'b0);
    send_beat(32767, 2, 1'b0);
    idle(3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle(3);
    for (int ph = 0; ph < 4; ph++) send_beat(-32768, ph, 1'b0);
    send_beat(32767, 3, 1'b0);
    idle(4);

    // Eight back-to-back beats with a four-cycle stall; phase churns while stalled
    sent = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (sent < 8) begin
        in_valid = 1'b1;
        x = IN_W'(1000 * (sent + 1) - 3000);
        phase = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && ir_a) sent++;
      if (in_valid && !ir_a) saw_stall = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("b2b_sent", sent, 8);
    chk("b2b_in_ready_dropped", longint'(saw_stall), 1);
    idle(4);

    // Randomized traffic with a reset dropped in mid-stream
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 7);
      if (k == 0) x = 16'sh7fff;
      else if (k == 1) x = 16'sh8000;
      else x = IN_W'($urandom);
      phase = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 15) == 0);
      rst = (c == 300);
      step();
    end
    rst = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Reset with two beats held in flight
    out_ready = 1'b0;
    send_beat(1234, 1, 1'b0);
    send_beat(-4321, 2, 1'b0);
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Drain with a bounded wait
    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) step();
    chk("drain_q18", q0.size(), 0);
    chk("drain_q20", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
